msx_slot_expander_ctrl: RTL and testbench
=========================================

Name: msx_slot_expander_ctrl

Overview:
Parametrised primary/secondary slot controller with an integrated MSX2 memory-mapper and external-memory handshake.
- Decodes the primary slot register (I/O A8h), per-slot secondary registers (FFFFh) and mapper page registers (I/O FCh–FFh).
- Resolves each CPU memory cycle to slot, subslot, page and bank.
- Drives a request/ready memory port and holds the Z80 in WAIT until data is returned.
- Sits between the CPU bus and the slot memory arbiter (SDRAM/BRAM), replacing the fixed 4x4 slot decode.

Parameters:
EXPANDED_MASK, 4'b1000, bit n set = primary slot n is expanded (has an FFFFh subslot register)
BANK_WIDTH, 8, width of each mapper page register; 1..8
MEM_AW, 25, width of mem_addr
TIMEOUT, 255, max clk_en ticks in WAIT_RDY before forced completion; 1..255

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clk_en  in  1  CPU clock enable; all state updates qualified by it
cpu_addr  in  16  CPU address
cpu_dout  in  8  CPU write data
cpu_din  out  8  read data to CPU
cpu_din_oe  out  1  cpu_din valid (register read or completed memory read)
cpu_rd  in  1  CPU read strobe
cpu_wr  in  1  CPU write strobe
cpu_mreq  in  1  memory request
cpu_iorq  in  1  I/O request
cpu_wait  out  1  Z80 WAIT, active-high
slot  out  2  primary slot of current page
subslot  out  2  secondary slot (0 if slot not expanded)
mem_addr  out  MEM_AW  {bank, cpu_addr[13:0]}, zero-extended or truncated to MEM_AW
mem_rd  out  1  one-cycle read request
mem_wr  out  1  one-cycle write request
mem_din  out  8  write data (registered cpu_dout)
mem_dout  in  8  read data
mem_ready  in  1  single-cycle completion pulse
timeout  out  1  sticky; set on forced completion, cleared by reset

Behaviour:
- Reset (async, reset_n=0):
  - A8 reg=00h; all subslot regs=00h; mapper page p = (3-p) mod 2^BANK_WIDTH.
  - FSM=IDLE; cpu_wait=0, mem_rd=0, mem_wr=0, cpu_din_oe=0, timeout=0; cpu_din=FFh.
  - Reset asserted mid-cycle drops all strobes immediately. mem_ready arriving after reset is ignored.
- Page decode: page=cpu_addr[15:14]; slot=A8[2p+1:2p]; subslot=sub[slot][2p+1:2p] if EXPANDED_MASK[slot], else 0; bank=mapper[page].
- I/O registers (cpu_iorq, addr[7:0]):
  - Write to A8h updates A8 reg.
  - Write to FCh+p updates mapper[p] with cpu_dout[BANK_WIDTH-1:0].
  - Reads are combinational, with cpu_din_oe=1:
    - A8h returns A8 reg.
    - FCh+p returns mapper[p] with unused upper bits read as 1.
  - No memory cycle is issued for I/O.
- FFFFh: when slot of page 3 is expanded:
  - Write sets sub[slot].
  - Read returns ~sub[slot] with cpu_din_oe=1.
  - Neither issues a memory cycle.
  - For a non-expanded slot, FFFFh is ordinary memory.
- Memory FSM (advances on clk_en):
  - IDLE: on cpu_mreq&(cpu_rd|cpu_wr), not an FFFFh register hit:
    - latch mem_addr and mem_din;
    - pulse mem_rd or mem_wr (exactly one clk);
    - set cpu_wait=1 in the same cycle;
    - go to WAIT_RDY and clear the wait counter.
  - WAIT_RDY: count clk_en ticks.
    - On mem_ready: latch mem_dout and go to DONE.
    - When the counter reaches TIMEOUT: latch FFh, set timeout, go to DONE.
    - mem_ready and timeout in the same cycle: mem_ready wins and timeout stays unchanged.
  - DONE: cpu_wait=0; for reads, cpu_din=latched data and cpu_din_oe=1. Stay in DONE until cpu_mreq=0, then go to IDLE.
  - The next request is accepted only from IDLE, so back-to-back cycles need an mreq deassertion in between.
- Register writes during WAIT_RDY/DONE: impossible on the CPU bus, so they are ignored.
- Latched mem_addr is unaffected by register changes after the request.
- cpu_din=FFh whenever cpu_din_oe=0.

Test Plan:
- Reset release → A8=00h; I/O read FEh returns (BANK_WIDTH=3) F9h; FFh returns F8h; cpu_wait=0.
- OUT A8h,C0h; write FFFFh=24h (slot 3 expanded) → read FFFFh returns DBh; read 8000h gives slot=0; read C000h gives slot=3, subslot=0; no mem_rd for the FFFFh access.
- OUT FEh,05h; read 8123h, mem_ready after 4 clk, mem_dout=5Ah:
  - mem_addr=14123h; mem_rd pulses 1 clk;
  - cpu_wait high 4 clk;
  - cpu_din=5Ah with oe until mreq drops.
- Write 4000h=77h with mem_ready never asserted, TIMEOUT=8:
  - cpu_wait released after 8 clk_en ticks; timeout=1; mem_wr pulsed exactly once.
- Drop reset_n while in WAIT_RDY, then pulse mem_ready → cpu_wait=0 immediately; FSM IDLE; registers at reset values; no cpu_din_oe.
- clk_en=1 every 3rd clk → FSM/timeout counter advance only on enabled cycles; mem_rd width still 1 clk.

Source files
------------

// File: rtl/msx_slot_expander_ctrl.sv
// MSX primary/secondary slot decoder with an MSX2 memory mapper.
// An external request/ready memory port holds the Z80 in WAIT until data returns.
module msx_slot_expander_ctrl #(
    parameter logic [3:0] EXPANDED_MASK = 4'b1000,
    parameter int         BANK_WIDTH    = 8,
    parameter int         MEM_AW        = 25,
    parameter int         TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_din_oe,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_mreq,
    input  logic              cpu_iorq,
    output logic              cpu_wait,
    output logic [1:0]        slot,
    output logic [1:0]        subslot,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ready,
    output logic              timeout
);
    typedef enum logic [1:0] {IDLE, WAIT_RDY, DONE} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                state, state_next;
    logic [7:0]            a8_reg;
    logic [7:0]            sub_reg [4];
    logic [BANK_WIDTH-1:0] mapper  [4];
    logic [7:0]            wait_cnt;
    logic [7:0]            rd_data;
    logic                  rd_cycle;

    logic [1:0] page;
    logic       ffff_hit, io_a8, io_map, mem_req, reg_we;
    logic       start, finish_ready, finish_timeout, cnt_inc;
    logic [7:0] map_rd;

    assign page     = cpu_addr[15:14];
    assign slot     = a8_reg[{page, 1'b0} +: 2];
    assign subslot  = EXPANDED_MASK[slot] ? sub_reg[slot][{page, 1'b0} +: 2] : 2'b00;
    assign ffff_hit = cpu_mreq && (cpu_addr == 16'hFFFF) && EXPANDED_MASK[a8_reg[7:6]];
    assign io_a8    = cpu_iorq && (cpu_addr[7:0] == 8'hA8);
    assign io_map   = cpu_iorq && (cpu_addr[7:2] == 6'b111111);
    assign mem_req  = cpu_mreq && (cpu_rd || cpu_wr) && !ffff_hit;
    assign reg_we   = clk_en && (state == IDLE) && cpu_wr;
    assign cpu_wait = (state == WAIT_RDY);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next     = state;
        start          = 1'b0;
        finish_ready   = 1'b0;
        finish_timeout = 1'b0;
        cnt_inc        = 1'b0;
        if (clk_en) begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        start      = 1'b1;
                        state_next = WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (mem_ready) begin
                        finish_ready = 1'b1;
                        state_next   = DONE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        finish_timeout = 1'b1;
                        state_next     = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                DONE: begin
                    if (!cpu_mreq) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        map_rd                 = 8'hFF;
        map_rd[BANK_WIDTH-1:0] = mapper[cpu_addr[1:0]];
    end

    always_comb begin
        cpu_din_oe = 1'b0;
        cpu_din    = 8'hFF;
        if (state == DONE && rd_cycle) begin
            cpu_din_oe = 1'b1;
            cpu_din    = rd_data;
        end else if (cpu_rd && io_a8) begin
            cpu_din_oe = 1'b1;
            cpu_din    = a8_reg;
        end else if (cpu_rd && io_map) begin
            cpu_din_oe = 1'b1;
            cpu_din    = map_rd;
        end else if (cpu_rd && ffff_hit) begin
            cpu_din_oe = 1'b1;
            cpu_din    = ~sub_reg[a8_reg[7:6]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a8_reg   <= 8'h00;
            // NOTE: these small register arrays are reset because software expects the power-on mapping.
            for (int i = 0; i < 4; i++) begin
                sub_reg[i] <= 8'h00;
                mapper[i]  <= BANK_WIDTH'(3 - i);
            end
            wait_cnt <= 8'h00;
            rd_data  <= 8'hFF;
            rd_cycle <= 1'b0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_din  <= 8'h00;
            timeout  <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (start) begin
                mem_addr <= MEM_AW'({mapper[page], cpu_addr[13:0]});
                mem_din  <= cpu_dout;
                mem_rd   <= cpu_rd;
                mem_wr   <= !cpu_rd;
                rd_cycle <= cpu_rd;
                wait_cnt <= 8'h00;
            end
            if (cnt_inc)      wait_cnt <= wait_cnt + 8'd1;
            if (finish_ready) rd_data  <= mem_dout;
            if (finish_timeout) begin
                rd_data <= 8'hFF;
                timeout <= 1'b1;
            end
            if (reg_we && io_a8)    a8_reg <= cpu_dout;
            if (reg_we && io_map)   mapper[cpu_addr[1:0]] <= cpu_dout[BANK_WIDTH-1:0];
            if (reg_we && ffff_hit) sub_reg[a8_reg[7:6]] <= cpu_dout;
        end
    end

endmodule

// File: tb/tb_msx_slot_expander_ctrl.sv
// Randomised self-checking bench for msx_slot_expander_ctrl against a
// register-file model of the slot, subslot and mapper state.
`timescale 1ns/1ps
module tb_msx_slot_expander_ctrl;
    localparam logic [3:0] EXP_MASK = 4'b1000;
    localparam int BW = 3;
    localparam int AW = 25;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n, clk_en;
    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_dout, cpu_din, mem_din, mem_dout;
    logic          cpu_din_oe, cpu_rd, cpu_wr, cpu_mreq, cpu_iorq, cpu_wait;
    logic [1:0]    slot, subslot;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr, mem_ready, timeout;

    int n_pass  = 0;
    int n_total = 0;
    bit div3    = 0;
    int phase   = 0;

    logic [7:0] m_a8;
    logic [7:0] m_sub [4];
    int         m_map [4];
    bit         m_to;

    msx_slot_expander_ctrl #(
        .EXPANDED_MASK(EXP_MASK), .BANK_WIDTH(BW), .MEM_AW(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_din_oe(cpu_din_oe),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq),
        .cpu_wait(cpu_wait), .slot(slot), .subslot(subslot), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_ready(mem_ready), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_reset();
        m_a8 = 8'h00;
        m_to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_sub[i] = 8'h00;
            m_map[i] = (3 - i) % (1 << BW);
        end
    endtask

    function automatic logic [1:0] exp_slot(input logic [15:0] a);
        int p = int'(a[15:14]);
        return 2'((int'(m_a8) >> (2 * p)) & 3);
    endfunction

    function automatic logic [1:0] exp_sub(input logic [15:0] a);
        int p = int'(a[15:14]);
        int s = int'(exp_slot(a));
        return EXP_MASK[s] ? 2'((int'(m_sub[s]) >> (2 * p)) & 3) : 2'd0;
    endfunction

    function automatic bit ffff_is_reg();
        return EXP_MASK[m_a8[7:6]];
    endfunction

    function automatic logic [7:0] exp_map_read(input int p);
        return 8'(m_map[p] | (255 - ((1 << BW) - 1)));
    endfunction

    // ---------------- bus primitives ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (div3) begin
            phase  = (phase + 1) % 3;
            clk_en = (phase == 0);
        end else begin
            clk_en = 1'b1;
        end
    endtask

    task automatic tick_en();
        bit was_en;
        for (int i = 0; i < 8; i++) begin
            was_en = clk_en;
            tick();
            if (was_en) break;
        end
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        cpu_addr = {8'h00, a};
        cpu_dout = d;
        cpu_iorq = 1'b1;
        cpu_wr   = 1'b1;
        tick_en();
        cpu_iorq = 1'b0;
        cpu_wr   = 1'b0;
        if (a == 8'hA8) m_a8 = d;
        if (a >= 8'hFC) m_map[a - 8'hFC] = int'(d) & ((1 << BW) - 1);
    endtask

    task automatic io_read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        cpu_addr = {8'h00, a};
        cpu_iorq = 1'b1;
        cpu_rd   = 1'b1;
        #1;
        n_total++;
        if (cpu_din !== exp) $display("FAIL %s din got %h exp %h", name, cpu_din, exp);
        else n_pass++;
        n_total++;
        if (cpu_din_oe !== 1'b1) $display("FAIL %s oe got %b exp 1", name, cpu_din_oe);
        else n_pass++;
        cpu_iorq = 1'b0;
        cpu_rd   = 1'b0;
    endtask

    task automatic ffff_access(input string name, input bit wr, input logic [7:0] d);
        int pulses = 0;
        cpu_addr = 16'hFFFF;
        cpu_dout = d;
        cpu_mreq = 1'b1;
        cpu_rd   = !wr;
        cpu_wr   = wr;
        #1;
        if (!wr) begin
            n_total++;
            if (cpu_din !== ~m_sub[m_a8[7:6]] || cpu_din_oe !== 1'b1)
                $display("FAIL %s din/oe got %h/%b exp %h/1", name, cpu_din, cpu_din_oe, ~m_sub[m_a8[7:6]]);
            else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            tick_en();
            if (mem_rd || mem_wr) pulses++;
        end
        n_total++;
        if (pulses != 0) $display("FAIL %s mem pulses got %0d exp 0", name, pulses);
        else n_pass++;
        cpu_mreq = 1'b0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        if (wr) m_sub[m_a8[7:6]] = d;
    endtask

    // One full memory cycle; ready_tick is the WAIT_RDY clk_en tick carrying mem_ready (0 = never).
    task automatic do_mem_cycle(input string name, input logic [15:0] addr, input bit wr,
                                input logic [7:0] wdata, input int ready_tick, input logic [7:0] rdata);
        logic [1:0]    e_slot, e_sub, g_slot, g_sub;
        logic [AW-1:0] e_addr, g_addr;
        logic [7:0]    e_data, g_din, g_mdin;
        logic          g_oe;
        int  e_ticks, e_wait;
        bit  e_to;
        int  n_rd = 0, n_wr = 0, wclk = 0, en_ticks = 0, extra = 0;
        bit  seen = 0, done = 0;

        e_slot  = exp_slot(addr);
        e_sub   = exp_sub(addr);
        e_to    = !(ready_tick >= 1 && ready_tick <= TO);
        e_ticks = e_to ? TO : ready_tick;
        e_wait  = e_ticks * (div3 ? 3 : 1);
        e_addr  = AW'((m_map[addr[15:14]] << 14) + int'(addr[13:0]));
        e_data  = e_to ? 8'hFF : rdata;
        g_addr  = '0;
        g_slot  = 2'b00;
        g_sub   = 2'b00;

        cpu_addr = addr;
        cpu_dout = wdata;
        cpu_rd   = !wr;
        cpu_wr   = wr;
        cpu_mreq = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (cpu_wait && clk_en) begin
                en_ticks++;
                mem_ready = (en_ticks == ready_tick);
                mem_dout  = mem_ready ? rdata : 8'($urandom);
            end
            tick();
            mem_ready = 1'b0;
            if (c == 0) begin
                g_slot = slot;
                g_sub  = subslot;
            end
            if (mem_rd) begin n_rd++; g_addr = mem_addr; end
            if (mem_wr) begin n_wr++; g_addr = mem_addr; end
            if (cpu_wait) begin
                seen = 1;
                wclk++;
            end else if (seen) begin
                done = 1;
                break;
            end
        end
        g_din  = cpu_din;
        g_oe   = cpu_din_oe;
        g_mdin = mem_din;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_rd || mem_wr) extra++;
        end
        m_to = m_to | e_to;

        n_total++; if (g_slot !== e_slot) $display("FAIL %s slot got %0d exp %0d", name, g_slot, e_slot); else n_pass++;
        n_total++; if (g_sub !== e_sub) $display("FAIL %s subslot got %0d exp %0d", name, g_sub, e_sub); else n_pass++;
        n_total++; if (!done) $display("FAIL %s completion got none exp cpu_wait release", name); else n_pass++;
        n_total++; if (n_rd != (wr ? 0 : 1)) $display("FAIL %s mem_rd clks got %0d exp %0d", name, n_rd, wr ? 0 : 1); else n_pass++;
        n_total++; if (n_wr != (wr ? 1 : 0)) $display("FAIL %s mem_wr clks got %0d exp %0d", name, n_wr, wr ? 1 : 0); else n_pass++;
        n_total++; if (g_addr !== e_addr) $display("FAIL %s mem_addr got %h exp %h", name, g_addr, e_addr); else n_pass++;
        n_total++; if (wclk != e_wait) $display("FAIL %s wait clks got %0d exp %0d", name, wclk, e_wait); else n_pass++;
        if (wr) begin
            n_total++; if (g_mdin !== wdata) $display("FAIL %s mem_din got %h exp %h", name, g_mdin, wdata); else n_pass++;
            n_total++; if (g_oe !== 1'b0) $display("FAIL %s oe got %b exp 0", name, g_oe); else n_pass++;
        end else begin
            n_total++; if (g_din !== e_data) $display("FAIL %s cpu_din got %h exp %h", name, g_din, e_data); else n_pass++;
            n_total++; if (g_oe !== 1'b1) $display("FAIL %s oe got %b exp 1", name, g_oe); else n_pass++;
        end
        n_total++; if (timeout !== m_to) $display("FAIL %s timeout got %b exp %b", name, timeout, m_to); else n_pass++;
        n_total++; if (extra != 0) $display("FAIL %s pulses while held got %0d exp 0", name, extra); else n_pass++;

        cpu_mreq = 1'b0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        tick_en();
        n_total++;
        if (cpu_din_oe !== 1'b0 || cpu_din !== 8'hFF)
            $display("FAIL %s after mreq drop din/oe got %h/%b exp ff/0", name, cpu_din, cpu_din_oe);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_total++;
        if (cpu_wait !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || timeout !== 1'b0)
            $display("FAIL reset strobes got wait=%b rd=%b wr=%b to=%b exp all 0", cpu_wait, mem_rd, mem_wr, timeout);
        else n_pass++;
        n_total++;
        if (cpu_din !== 8'hFF || cpu_din_oe !== 1'b0)
            $display("FAIL reset din/oe got %h/%b exp ff/0", cpu_din, cpu_din_oe);
        else n_pass++;
        io_read_check("reset_a8", 8'hA8, 8'h00);
        io_read_check("reset_fc", 8'hFC, 8'hFB);
        io_read_check("reset_fe", 8'hFE, 8'hF9);
        io_read_check("reset_ff", 8'hFF, 8'hF8);
    endtask

    task automatic test_slot_regs();
        io_write(8'hA8, 8'hC0);
        io_read_check("a8_rb", 8'hA8, 8'hC0);
        ffff_access("ffff_wr", 1'b1, 8'h24);
        ffff_access("ffff_rd", 1'b0, 8'h00);
        do_mem_cycle("rd_8000", 16'h8000, 1'b0, 8'h00, 1, 8'h11);
        do_mem_cycle("rd_c000", 16'hC000, 1'b0, 8'h00, 2, 8'h22);
        io_write(8'hA8, 8'h00);
        do_mem_cycle("ffff_as_mem", 16'hFFFF, 1'b0, 8'h00, 1, 8'h33);
        io_write(8'hA8, 8'hC4);
        do_mem_cycle("rd_sub_4000", 16'h4000, 1'b0, 8'h00, 1, 8'h44);
    endtask

    task automatic test_mapper();
        io_write(8'hFE, 8'h05);
        io_read_check("map_fe_rb", 8'hFE, 8'hFD);
        do_mem_cycle("rd_8123", 16'h8123, 1'b0, 8'h00, 4, 8'h5A);
    endtask

    task automatic test_timeout();
        do_mem_cycle("wr_timeout", 16'h4000, 1'b1, 8'h77, 0, 8'h00);
        do_mem_cycle("ready_at_limit", 16'h2000, 1'b0, 8'h00, TO, 8'hA5);
    endtask

    task automatic test_back_to_back();
        do_mem_cycle("b2b_a", 16'h1234, 1'b0, 8'h00, 1, 8'h01);
        do_mem_cycle("b2b_b", 16'h5678, 1'b1, 8'hEE, 2, 8'h00);
    endtask

    task automatic test_clk_en_div3();
        div3   = 1;
        phase  = 0;
        clk_en = 1'b0;
        do_mem_cycle("div3_rd", 16'h8123, 1'b0, 8'h00, 3, 8'hC3);
        do_mem_cycle("div3_to", 16'h0042, 1'b1, 8'h9A, 0, 8'h00);
        io_write(8'hFD, 8'h06);
        io_read_check("div3_fd", 8'hFD, 8'hFE);
        div3   = 0;
        clk_en = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [15:0] a;
        int          op, p;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 7);
            d  = 8'($urandom);
            p  = $urandom_range(0, 3);
            case (op)
                0: io_write(8'hA8, d);
                1: io_write(8'(8'hFC + p), d);
                2: if (ffff_is_reg()) ffff_access("rnd_ffff_wr", 1'b1, d);
                   else io_read_check("rnd_map", 8'(8'hFC + p), exp_map_read(p));
                3: if (ffff_is_reg()) ffff_access("rnd_ffff_rd", 1'b0, 8'h00);
                   else io_read_check("rnd_a8", 8'hA8, m_a8);
                default: begin
                    a = 16'($urandom);
                    if (a == 16'hFFFF) a = 16'hFFFE;
                    do_mem_cycle("rnd_mem", a, 1'($urandom), d, $urandom_range(0, 10), 8'($urandom));
                end
            endcase
        end
    endtask

    task automatic test_reset_mid_wait();
        cpu_addr = 16'h8000;
        cpu_rd   = 1'b1;
        cpu_mreq = 1'b1;
        tick_en();
        tick();
        tick();
        n_total++;
        if (cpu_wait !== 1'b1) $display("FAIL rst_pre_wait got %b exp 1", cpu_wait);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (cpu_wait !== 1'b0 || mem_rd !== 1'b0 || cpu_din_oe !== 1'b0 || timeout !== 1'b0)
            $display("FAIL rst_async got wait=%b rd=%b oe=%b to=%b exp all 0", cpu_wait, mem_rd, cpu_din_oe, timeout);
        else n_pass++;
        cpu_mreq = 1'b0;
        cpu_rd   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        model_reset();
        tick();
        mem_ready = 1'b1;
        mem_dout  = 8'h5A;
        tick();
        mem_ready = 1'b0;
        tick();
        n_total++;
        if (cpu_wait !== 1'b0 || cpu_din_oe !== 1'b0 || cpu_din !== 8'hFF)
            $display("FAIL rst_late_ready got wait=%b oe=%b din=%h exp 0/0/ff", cpu_wait, cpu_din_oe, cpu_din);
        else n_pass++;
        io_read_check("rst_a8", 8'hA8, 8'h00);
        io_read_check("rst_fe", 8'hFE, 8'hF9);
        io_read_check("rst_ff", 8'hFF, 8'hF8);
        do_mem_cycle("post_rst", 16'hC001, 1'b0, 8'h00, 2, 8'h3C);
    endtask

    initial begin
        reset_n   = 1'b0;
        clk_en    = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_dout  = 8'h00;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_mreq  = 1'b0;
        cpu_iorq  = 1'b0;
        mem_dout  = 8'h00;
        mem_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        test_reset();
        test_slot_regs();
        test_mapper();
        test_timeout();
        test_back_to_back();
        test_clk_en_div3();
        test_random();
        test_reset_mid_wait();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
